// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, bus layouts, load
// type codes, FSM state encodings and the byte/half extension helpers.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 76;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_FWD_BUS_WD   = 38;

    // Load type codes carried in the EXE->MEM bus; 5..7 behave as LW.
    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    // Load-response FSM: idle / waiting on data_ok / holding buffered data.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef struct packed {
        logic [2:0]  ld_type;
        logic [1:0]  addr_lo;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } es_bus_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_bus_t;

    // Byte to word, sign- or zero-extended.
    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sign_en);
        return {{24{sign_en & b[7]}}, b};
    endfunction

    // Halfword to word, sign- or zero-extended.
    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sign_en);
        return {{16{sign_en & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: picks the addressed byte/halfword out of
// the raw SRAM word and extends it to 32 bits.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane [2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            assign byte_lane[gi] = rdata[8*gi +: 8];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_half
            assign half_lane[gi] = rdata[16*gi +: 16];
        end
    endgenerate

    // Select and extend; addr_lo[0] is ignored for halfwords (misalignment is trapped upstream).
    always_comb begin
        data = rdata;
        case (ld_type)
            LD_LB:   data = ext8(byte_lane[addr_lo], 1'b1);
            LD_LBU:  data = ext8(byte_lane[addr_lo], 1'b0);
            LD_LH:   data = ext16(half_lane[addr_lo[1]], 1'b1);
            LD_LHU:  data = ext16(half_lane[addr_lo[1]], 1'b0);
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS pipeline MEM stage: latches the EXE->MEM bus, waits for the load
// response from data SRAM (buffering it if WB is stalled), aligns load data
// and presents the result to WB plus a forwarding/stall bus to decode.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus
);

    es_bus_t     in_bus;
    es_bus_t     bus_reg;
    ms_bus_t     out_bus;
    logic        ms_valid_reg;
    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic [31:0] rdata_buf_reg;
    logic [31:0] rdata_buf_next;
    logic        ms_ready_go;
    logic        ms_blocking;
    logic        data_now;
    logic [31:0] load_word;
    logic [31:0] load_data;
    logic [31:0] final_result;
    logic [31:0] fwd_value;

    assign in_bus = es_to_ms_bus;

    // data_ok only counts while a load is actually waiting for it.
    assign data_now    = (state_reg == ST_WAIT) && data_sram_data_ok;
    assign ms_ready_go = !bus_reg.res_from_mem || data_now || (state_reg == ST_HOLD);
    assign ms_allowin  = !ms_valid_reg || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_reg && ms_ready_go;
    assign ms_blocking = ms_valid_reg && bus_reg.res_from_mem && !ms_ready_go;

    // Fresh SRAM data is used straight through; a held load uses the buffer.
    assign load_word = (state_reg == ST_HOLD) ? rdata_buf_reg : data_sram_rdata;

    load_align u_load_align (
        .rdata   (load_word),
        .ld_type (bus_reg.ld_type),
        .addr_lo (bus_reg.addr_lo),
        .data    (load_data)
    );

    assign final_result = bus_reg.res_from_mem ? load_data : bus_reg.result;

    assign out_bus.gr_we        = bus_reg.gr_we;
    assign out_bus.dest         = bus_reg.dest;
    assign out_bus.final_result = final_result;
    assign out_bus.pc           = bus_reg.pc;
    assign ms_to_ws_bus         = out_bus;

    // Value is meaningless while blocking; drive zero so decode sees a clean bus.
    assign fwd_value  = ms_ready_go ? final_result : 32'd0;
    assign ms_fwd_bus = (ms_valid_reg && bus_reg.gr_we) ?
                        {ms_blocking, bus_reg.dest, fwd_value} : '0;

    // Next-state: a handshake restarts the FSM for the incoming instruction;
    // data arriving while WB stalls is parked in the buffer.
    always_comb begin
        state_next     = state_reg;
        rdata_buf_next = rdata_buf_reg;
        if (ms_allowin) begin
            state_next = (es_to_ms_valid && in_bus.res_from_mem) ? ST_WAIT : ST_IDLE;
        end else if (data_now) begin
            state_next     = ST_HOLD;
            rdata_buf_next = data_sram_rdata;
        end
    end

    // Pipeline valid bit follows the upstream handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_reg <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid_reg <= es_to_ms_valid;
        end
    end

    // Payload register captures only on an accepted transfer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_reg <= '0;
        end else if (es_to_ms_valid && ms_allowin) begin
            bus_reg <= in_bus;
        end
    end

    // FSM state and load-data buffer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            rdata_buf_reg <= 32'd0;
        end else begin
            state_reg     <= state_next;
            rdata_buf_reg <= rdata_buf_next;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a per-instruction model predicts every
// output each cycle, and literal expectations pin the key scenarios.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [75:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [37:0] ms_fwd_bus;

    int n_tests = 0;
    int n_fail  = 0;
    bit allow_stray = 1'b0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_fwd_bus        (ms_fwd_bus)
    );

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [75:0] mk(input logic [2:0] ld, input logic [1:0] a, input logic load,
                                       input logic we, input logic [4:0] dest,
                                       input logic [31:0] res, input logic [31:0] pc);
        return {ld, a, load, we, dest, res, pc};
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [2:0]  ld;
        logic [1:0]  a;
        logic        load;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] res;
        logic [31:0] pc;
    } ins_t;

    ins_t        m_ins = '{default: '0};
    ins_t        n_ins = '{default: '0};
    bit          m_valid = 1'b0, n_valid = 1'b0;
    bit          m_got = 1'b0, n_got = 1'b0;
    logic [31:0] m_word = '0, n_word = '0;

    // Load alignment written as shift-and-extend arithmetic on the raw word.
    function automatic logic [31:0] model_align(input logic [2:0] ld, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] sh;
        case (ld)
            3'd1, 3'd2: begin
                sh = w >> (8 * a);
                sh = sh & 32'hFF;
                if (ld == 3'd1 && sh >= 32'h80) sh = sh - 32'h100;
                return sh;
            end
            3'd3, 3'd4: begin
                sh = w >> (a >= 2'd2 ? 16 : 0);
                sh = sh & 32'hFFFF;
                if (ld == 3'd3 && sh >= 32'h8000) sh = sh - 32'h10000;
                return sh;
            end
            default: return w;
        endcase
    endfunction

    function automatic ins_t decode(input logic [75:0] b);
        ins_t r;
        r.ld = b[75:73]; r.a = b[72:71]; r.load = b[70]; r.we = b[69];
        r.dest = b[68:64]; r.res = b[63:32]; r.pc = b[31:0];
        return r;
    endfunction

    // Compare outputs against the model and compute the model's next state.
    always @(negedge clk) begin
        bit          data_now, ready, e_allowin, blocking;
        logic [31:0] fin;
        if (!resetn) begin
            chk("rst_valid", 70'(ms_to_ws_valid), 70'd0);
            chk("rst_fwd", 70'(ms_fwd_bus), 70'd0);
            chk("rst_allowin", 70'(ms_allowin), 70'd1);
            n_valid = 0; n_got = 0;
        end else begin
            if (data_sram_data_ok && !allow_stray) begin
                n_tests++;
                if (!(m_valid && m_ins.load && !m_got)) begin
                    n_fail++;
                    $display("FAIL protocol: data_ok while no load waiting at %0t", $time);
                end
            end
            data_now  = m_valid && m_ins.load && !m_got && data_sram_data_ok;
            ready     = m_valid && (!m_ins.load || m_got || data_now);
            fin       = m_ins.load ? model_align(m_ins.ld, m_ins.a, m_got ? m_word : data_sram_rdata) : m_ins.res;
            e_allowin = !m_valid || (ready && ws_allowin);
            blocking  = m_valid && m_ins.load && !ready;
            chk("m_valid", 70'(ms_to_ws_valid), 70'(ready));
            chk("m_allowin", 70'(ms_allowin), 70'(e_allowin));
            if (ready)
                chk("m_bus", ms_to_ws_bus, {m_ins.we, m_ins.dest, fin, m_ins.pc});
            if (m_valid && m_ins.we) begin
                chk("m_fwd_hdr", 70'(ms_fwd_bus[37:32]), 70'({blocking, m_ins.dest}));
                if (ready) chk("m_fwd_val", 70'(ms_fwd_bus[31:0]), 70'(fin));
            end else begin
                chk("m_fwd_zero", 70'(ms_fwd_bus), 70'd0);
            end
            if (ready && ws_allowin)
                $display("[TB] retire pc=%h dest=%0d we=%0d result=%h", m_ins.pc, m_ins.dest, m_ins.we, fin);
            n_ins = m_ins; n_got = m_got; n_word = m_word; n_valid = m_valid;
            if (e_allowin) begin
                n_valid = es_to_ms_valid;
                if (es_to_ms_valid) begin
                    n_ins = decode(es_to_ms_bus);
                    n_got = 0;
                end
            end else if (data_now) begin
                n_got = 1; n_word = data_sram_rdata;
            end
        end
    end

    always @(posedge clk) begin
        if (!resetn) begin
            m_valid = 0; m_got = 0;
        end else begin
            m_valid = n_valid; m_ins = n_ins; m_got = n_got; m_word = n_word;
        end
    end

    // ---------------- directed stimulus ----------------
    logic        last_valid;
    logic [31:0] last_final;
    logic [37:0] last_fwd;

    task automatic step(input logic ev, input logic [75:0] b, input logic ws,
                        input logic ok, input logic [31:0] rd);
        es_to_ms_valid = ev; es_to_ms_bus = b; ws_allowin = ws;
        data_sram_data_ok = ok; data_sram_rdata = rd;
        @(negedge clk);
        last_valid = ms_to_ws_valid;
        last_final = ms_to_ws_bus[63:32];
        last_fwd   = ms_fwd_bus;
        @(posedge clk); #1;
    endtask

    typedef struct { logic [2:0] ld; logic [1:0] a; logic [31:0] w; logic [31:0] exp; } ld_vec_t;
    ld_vec_t vecs [7] = '{
        '{3'd2, 2'd1, 32'h1234_80FF, 32'h0000_0080},
        '{3'd1, 2'd0, 32'h0000_007F, 32'h0000_007F},
        '{3'd3, 2'd0, 32'h1234_8001, 32'hFFFF_8001},
        '{3'd3, 2'd3, 32'h9ABC_0000, 32'hFFFF_9ABC},
        '{3'd4, 2'd1, 32'h1111_F00D, 32'h0000_F00D},
        '{3'd7, 2'd2, 32'hCAFE_BABE, 32'hCAFE_BABE},
        '{3'd1, 2'd2, 32'h0055_0000, 32'h0000_0055}
    };

    initial begin
        resetn = 1'b0; es_to_ms_valid = 0; es_to_ms_bus = '0; ws_allowin = 0;
        data_sram_data_ok = 0; data_sram_rdata = '0;
        #2;
        chk("reset_allowin", 70'(ms_allowin), 70'd1);
        chk("reset_valid", 70'(ms_to_ws_valid), 70'd0);
        chk("reset_fwd", 70'(ms_fwd_bus), 70'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b1;
        step(0, '0, 1, 0, 0);

        // 1: ADDU passes with zero latency.
        step(1, mk(3'd0, 2'd0, 0, 1, 5'd5, 32'h1234, 32'h100), 1, 0, 0);
        step(0, '0, 1, 0, 0);
        chk("t1_valid", 70'(last_valid), 70'd1);
        chk("t1_result", 70'(last_final), 70'h1234);
        chk("t1_fwd", 70'(last_fwd), 70'({1'b0, 5'd5, 32'h1234}));

        // 2: LB addr_lo=3, data after two waiting cycles.
        step(1, mk(3'd1, 2'd3, 1, 1, 5'd6, 32'h5000_0003, 32'h104), 1, 0, 0);
        step(0, '0, 1, 0, 32'hFFFF_FFFF);
        chk("t2_block1", 70'(last_fwd[37]), 70'd1);
        step(0, '0, 1, 0, 32'hFFFF_FFFF);
        chk("t2_block2", 70'(last_fwd[37]), 70'd1);
        step(0, '0, 1, 1, 32'h80FF_0000);
        chk("t2_valid", 70'(last_valid), 70'd1);
        chk("t2_result", 70'(last_final), 70'hFFFF_FF80);
        chk("t2_unblock", 70'(last_fwd[37]), 70'd0);

        // 3: LHU addr_lo=2, WB stalled for three cycles after data_ok.
        step(1, mk(3'd4, 2'd2, 1, 1, 5'd7, 32'h5000_0002, 32'h108), 1, 0, 0);
        step(0, '0, 1, 0, 0);
        step(0, '0, 0, 1, 32'hBEEF_1234);
        step(0, '0, 0, 0, 32'hDEAD_DEAD);
        step(0, '0, 0, 0, 32'hDEAD_DEAD);
        chk("t3_hold_result", 70'(last_final), 70'h0000_BEEF);
        step(0, '0, 1, 0, 32'hDEAD_DEAD);
        chk("t3_valid", 70'(last_valid), 70'd1);
        chk("t3_result", 70'(last_final), 70'h0000_BEEF);
        step(0, '0, 1, 0, 0);
        chk("t3_drained", 70'(last_valid), 70'd0);

        // 4: back-to-back LW with data_ok in consecutive cycles.
        step(1, mk(3'd0, 2'd0, 1, 1, 5'd8, 32'h5000_0010, 32'h10C), 1, 0, 0);
        step(1, mk(3'd0, 2'd0, 1, 1, 5'd9, 32'h5000_0014, 32'h110), 1, 1, 32'h1111_1111);
        chk("t4_first", 70'(last_final), 70'h1111_1111);
        step(0, '0, 1, 1, 32'h2222_2222);
        chk("t4_second_valid", 70'(last_valid), 70'd1);
        chk("t4_second", 70'(last_final), 70'h2222_2222);

        // 5: reset asserted mid-WAIT; stale data_ok afterwards is ignored.
        step(1, mk(3'd0, 2'd0, 1, 1, 5'd10, 32'h5000_0020, 32'h114), 1, 0, 0);
        step(0, '0, 1, 0, 0);
        resetn = 1'b0;
        #1;
        chk("t5_async_fwd", 70'(ms_fwd_bus), 70'd0);
        chk("t5_async_valid", 70'(ms_to_ws_valid), 70'd0);
        step(0, '0, 1, 0, 0);
        resetn = 1'b1;
        allow_stray = 1'b1;
        step(0, '0, 1, 1, 32'h3333_3333);
        chk("t5_stale", 70'(last_valid), 70'd0);
        allow_stray = 1'b0;

        // 6: store (gr_we=0) passes in one cycle with a silent forward bus.
        step(1, mk(3'd0, 2'd0, 0, 0, 5'd11, 32'h0000_0040, 32'h118), 1, 0, 0);
        step(0, '0, 1, 0, 0);
        chk("t6_valid", 70'(last_valid), 70'd1);
        chk("t6_fwd", 70'(last_fwd), 70'd0);

        // Alignment table: every load type and lane, including codes 5..7.
        for (int i = 0; i < 7; i++) begin
            step(1, mk(vecs[i].ld, vecs[i].a, 1, 1, 5'(12 + i), 32'h6000_0000, 32'h200 + 32'(4 * i)), 1, 0, 0);
            step(0, '0, 1, 1, vecs[i].w);
            chk($sformatf("align_%0d", i), 70'(last_final), 70'(vecs[i].exp));
        end
        step(0, '0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
